// File: rtl/rom_read_arbiter.sv
// Two-port read arbiter/sequencer driving a single-port ROM macro (cs/addr/dout).
// Build option: ROM_ARB_FIXED_PRIO_EN makes port 0 win every tie (round-robin otherwise).
module rom_read_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rom_cs,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY);

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  gnt_r;
  logic [2:0]            cnt_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  rom_cs_r;
  logic                  rsp0_valid_r;
  logic                  rsp1_valid_r;
  logic                  win_s;
  logic                  accept_s;
`ifndef ROM_ARB_FIXED_PRIO_EN
  logic                  last_r;
`endif

  // Winner selection: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    win_s = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      win_s = 1'b0;
`else
      win_s = ~last_r;
`endif
    end else if (req1_valid) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Reset dominates: no handshake completes in a reset cycle.
  assign accept_s   = (state_r == S_IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready = accept_s && !win_s;
  assign req1_ready = accept_s && win_s;

  assign rom_cs     = rom_cs_r;
  assign rom_addr   = addr_r;
  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign rsp0_data  = data_r;
  assign rsp1_data  = data_r;
  assign busy       = (state_r != S_IDLE);

  // Sequencer FSM: accept, one-cycle chip select, latency wait, response pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      addr_r       <= '0;
      gnt_r        <= 1'b0;
      cnt_r        <= 3'd0;
      data_r       <= '0;
      rom_cs_r     <= 1'b0;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      last_r       <= 1'b1;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          rsp0_valid_r <= 1'b0;
          rsp1_valid_r <= 1'b0;
          if (accept_s) begin
            addr_r   <= win_s ? req1_addr : req0_addr;
            gnt_r    <= win_s;
`ifndef ROM_ARB_FIXED_PRIO_EN
            last_r   <= win_s;
`endif
            rom_cs_r <= 1'b1;
            state_r  <= S_ISSUE;
          end else begin
            rom_cs_r <= 1'b0;
            state_r  <= S_IDLE;
          end
        end
        S_ISSUE: begin
          rom_cs_r <= 1'b0;
          cnt_r    <= LAT_LOAD;
          state_r  <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_r == 3'd1) begin
            data_r       <= rom_dout;
            rsp0_valid_r <= ~gnt_r;
            rsp1_valid_r <= gnt_r;
            state_r      <= S_RESP;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        S_RESP: begin
          rsp0_valid_r <= 1'b0;
          rsp1_valid_r <= 1'b0;
          state_r      <= S_IDLE;
        end
        default: begin
          rom_cs_r     <= 1'b0;
          rsp0_valid_r <= 1'b0;
          rsp1_valid_r <= 1'b0;
          state_r      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: directed scenarios plus randomized requests checked
// against a transaction-level arbitration/latency model; a second instance uses RD_LATENCY=3.
module tb_rom_read_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          v0, v1, r0, r1, rv0, rv1, cs, busy;
  logic [AW-1:0] a0, a1, raddr;
  logic [DW-1:0] rd0, rd1, dout;

  logic          b_v0, b_v1, b_r0, b_r1, b_rv0, b_rv1, b_cs, b_busy;
  logic [AW-1:0] b_a0, b_a1, b_raddr;
  logic [DW-1:0] b_rd0, b_rd1, b_dout;

  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] b_pipe [0:2];

  int n_checks = 0;
  int n_fail   = 0;
  bit model_last;

  rom_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_addr(a0), .req0_ready(r0), .rsp0_valid(rv0), .rsp0_data(rd0),
    .req1_valid(v1), .req1_addr(a1), .req1_ready(r1), .rsp1_valid(rv1), .rsp1_data(rd1),
    .rom_cs(cs), .rom_addr(raddr), .rom_dout(dout), .busy(busy)
  );

  rom_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_v0), .req0_addr(b_a0), .req0_ready(b_r0), .rsp0_valid(b_rv0), .rsp0_data(b_rd0),
    .req1_valid(b_v1), .req1_addr(b_a1), .req1_ready(b_r1), .rsp1_valid(b_rv1), .rsp1_data(b_rd1),
    .rom_cs(b_cs), .rom_addr(b_raddr), .rom_dout(b_dout), .busy(b_busy)
  );

  // ROM macros: data appears LAT cycles after the cs-sampling edge, garbage otherwise
  always @(posedge clk) dout <= cs ? mem[raddr] : 8'hEE;

  always @(posedge clk) begin
    b_pipe[0] <= b_cs ? mem[b_raddr] : 8'hEE;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_dout = b_pipe[LAT_B-1];

  function automatic logic [7:0] exp_data(input logic [9:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // Which port the arbiter should pick given the pending requests
  function automatic bit pick(input bit p0, input bit p1);
    if (p0 && p1) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      return 1'b0;
`else
      return !model_last;
`endif
    end
    return p1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on dut_a, entered at posedge+1 of an IDLE cycle
  task automatic serve(input bit p0, input bit p1, input logic [9:0] x0, input logic [9:0] x1);
    bit w;
    logic [9:0] wa;
    v0 = p0; v1 = p1; a0 = x0; a1 = x1;
    w  = pick(p0, p1);
    wa = w ? x1 : x0;
    @(negedge clk);
    check("accept_ready0", 32'(r0), 32'(!w));
    check("accept_ready1", 32'(r1), 32'(w));
    check("accept_busy", 32'(busy), 32'd0);
    model_last = w;
    @(posedge clk); #1;
    if (w) v1 = 1'b0; else v0 = 1'b0;
    @(negedge clk);
    check("issue_cs", 32'(cs), 32'd1);
    check("issue_addr", 32'(raddr), 32'(wa));
    check("issue_ready", 32'({r0, r1}), 32'd0);
    check("issue_busy", 32'(busy), 32'd1);
    for (int k = 0; k < LAT_A; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("wait_cs", 32'(cs), 32'd0);
      check("wait_rsp", 32'({rv0, rv1}), 32'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("resp_valid", 32'({rv0, rv1}), w ? 32'd1 : 32'd2);
    check("resp_data", 32'(w ? rd1 : rd0), 32'(exp_data(wa)));
    check("resp_cs", 32'(cs), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit p0, p1, w;
    logic [9:0] x0, x1;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hA5;
    model_last = 1'b1;
    rst = 1'b1;
    v0 = 1'b1; v1 = 1'b1; a0 = 10'h010; a1 = 10'h3FF;
    b_v0 = 1'b0; b_v1 = 1'b0; b_a0 = 10'h000; b_a1 = 10'h000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ready", 32'({r0, r1}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cs", 32'(cs), 32'd0);
    check("rst_addr", 32'(raddr), 32'd0);
    check("rst_rsp", 32'({rv0, rv1}), 32'd0);
    check("rst_data", 32'({rd0, rd1}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Tie from reset: 0, then 1 the cycle after RESP, then 0 again
    serve(1'b1, 1'b1, 10'h010, 10'h3FF);
    serve(1'b0, 1'b1, 10'h010, 10'h3FF);
    serve(1'b1, 1'b1, 10'h010, 10'h3FF);
    serve(1'b0, 1'b1, 10'h010, 10'h3FF);

    // Single read and address wrap
    serve(1'b1, 1'b0, 10'h003, 10'h000);
    serve(1'b0, 1'b1, 10'h000, 10'h3FF);
    serve(1'b0, 1'b1, 10'h000, 10'h000);

    // Reset during WAIT drops the read
    v0 = 1'b1; a0 = 10'h009;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp", 32'({rv0, rv1}), 32'd0);
    check("midrst_data", 32'(rd0), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_no_late_rsp", 32'({rv0, rv1}), 32'd0);
    @(posedge clk); #1;
    serve(1'b1, 1'b0, 10'h005, 10'h000);

    // Randomized requests; the loser keeps its request pending
    p0 = 1'b0; p1 = 1'b0; x0 = 10'h000; x1 = 10'h000;
    repeat (24) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin p0 = 1'b1; x0 = 10'($urandom); end
      if (!p1 && $urandom_range(0, 1) == 1) begin p1 = 1'b1; x1 = 10'($urandom); end
      if (!p0 && !p1) begin p1 = 1'b1; x1 = 10'($urandom); end
      w = pick(p0, p1);
      serve(p0, p1, x0, x1);
      if (w) p1 = 1'b0; else p0 = 1'b0;
    end
    v0 = 1'b0; v1 = 1'b0;

    // Latency 3 instance: response five cycles after accept
    b_v0 = 1'b1; b_a0 = 10'h007;
    @(negedge clk);
    check("lat3_ready", 32'(b_r0), 32'd1);
    @(posedge clk); #1;
    b_v0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("lat3_cs", 32'(b_cs), 32'(k == 1));
      check("lat3_rsp", 32'({b_rv0, b_rv1}), (k == 5) ? 32'd2 : 32'd0);
      if (k == 5) check("lat3_data", 32'(b_rd0), 32'h0A2);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("lat3_idle", 32'(b_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
